fetch_ifid_stage: RTL

Front end of the 5-stage pipeline: owns the fetch PC, drives the instruction-memory request/acknowledge handshake, and holds the IF/ID pipeline register. It is the consumer of the hazard unit's fetch/decode stall outputs and of decode-stage branch/jump redirects. An in-flight fetch squashed by a redirect is drained and its data discarded. If decode is not ready, a returned instruction is held in a one-entry buffer.

---
 rtl/fetch_ifid_stage.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fetch_ifid_stage.sv
// Fetch PC, imem request/ack handshake and IF/ID register with a one-entry hold buffer.
// Optional IF/ID load counters are built in when IFID_PERF_CNT_EN is defined.
module fetch_ifid_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_F,
  input  logic                  stall_D,
  input  logic                  pc_src_d,
  input  logic [ADDR_WIDTH-1:0] branch_target_d,
  input  logic                  jmp_d,
  input  logic [ADDR_WIDTH-1:0] jump_target_d,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic [ADDR_WIDTH-1:0] pc_plus4_d,
  output logic                  valid_d,
  output logic                  fetch_stall
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_bubbles
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DISCARD} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc4;
    logic                  valid;
  } ifid_t;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  ifid_t                 ifid_q, ifid_d;
  logic                  ifid_ld;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] hold_pc4_q, hold_pc4_d;
  logic [ADDR_WIDTH-1:0] pend_q, pend_d;

  logic                  stall, redirect;
  logic [ADDR_WIDTH-1:0] target, pc_plus4;

  always_comb begin
    stall    = stall_F | stall_D;
    redirect = ifid_q.valid & (pc_src_d | jmp_d) & ~stall_D;
    target   = jmp_d ? jump_target_d : branch_target_d;
    pc_plus4 = pc_q + ADDR_WIDTH'(4);
  end

  // ifid_d defaults to a bubble; ifid_ld gates whether IF/ID is written at all.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_d     = '0;
    ifid_ld    = 1'b0;
    hold_d     = hold_q;
    hold_pc4_d = hold_pc4_q;
    pend_d     = pend_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_d    = target;
            ifid_ld = 1'b1;
          end else if (stall) begin
            hold_d     = imem_rdata;
            hold_pc4_d = pc_plus4;
            state_d    = S_HOLD;
          end else begin
            ifid_d  = '{instr: imem_rdata, pc4: pc_plus4, valid: 1'b1};
            ifid_ld = 1'b1;
            pc_d    = pc_plus4;
          end
        end else if (redirect) begin
          pend_d  = target;
          state_d = S_DISCARD;
          ifid_ld = 1'b1;
        end else if (!stall_D) begin
          ifid_ld = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = S_FETCH;
          ifid_ld = 1'b1;
        end else if (!stall) begin
          ifid_d  = '{instr: hold_q, pc4: hold_pc4_q, valid: 1'b1};
          ifid_ld = 1'b1;
          pc_d    = pc_plus4;
          state_d = S_FETCH;
        end else if (!stall_D) begin
          // Decode moves on while fetch is frozen: feed it a bubble.
          ifid_ld = 1'b1;
        end
      end
      S_DISCARD: begin
        if (imem_ack) begin
          pc_d    = pend_q;
          state_d = S_FETCH;
        end
        ifid_ld = ~stall_D;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ifid_q     <= '0;
      hold_q     <= '0;
      hold_pc4_q <= '0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      hold_pc4_q <= hold_pc4_d;
      pend_q     <= pend_d;
      if (ifid_ld) ifid_q <= ifid_d;
    end
  end

  // Request is gated by rst_n so nothing is issued while reset is held.
  assign imem_req    = rst_n & (state_q != S_HOLD);
  assign imem_addr   = pc_q;
  assign fetch_stall = rst_n & (((state_q == S_FETCH) & ~imem_ack) | (state_q == S_DISCARD));
  assign instr_d     = ifid_q.instr;
  assign pc_plus4_d  = ifid_q.pc4;
  assign valid_d     = ifid_q.valid;

`ifdef IFID_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (ifid_ld) begin
      if (ifid_d.valid) perf_fetched_d = perf_fetched_q + 32'd1;
      else              perf_bubbles_d = perf_bubbles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule
